blink_timer: RTL

- Generates per-digit display-enable strobes for the 7-segment blanking stage, which passes a digit's segments when its enable is 1 and blanks them when it is 0.
- Sits directly upstream of that stage: one isOn bit per digit.
- Supports two modes:
  - continuous blinking while enabled;
  - a one-shot burst of N blinks with busy/done handshake.
- Digits outside the blink mask stay steadily on.

---
 rtl/blink_timer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - per-digit blink enable generator with continuous and burst modes
//
// Purpose: drives one isOn bit per digit for the 7-segment blanking stage.
//   Digits outside blink_mask stay on. Masked digits follow the blink phase,
//   either continuously while blink_en is high or for a one-shot burst of
//   burst_len blinks with a busy/done handshake.
//
// Optional feature macro: BLINK_PAUSE_EN (adds the pause input).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   blink_en    in   level, continuous blinking while high
//   start       in   one-cycle pulse, begins a burst of burst_len blinks
//   burst_len   in   [3:0] blink count, sampled when start is accepted
//   blink_mask  in   [DIGITS-1:0] 1 = digit participates in blinking
//   pause       in   (BLINK_PAUSE_EN only) freezes blink timing while high
//   isOn        out  [DIGITS-1:0] per-digit enable to the blanking stage
//   phase       out  current blink phase, 1 = on
//   busy        out  high while a burst is in progress
//   done        out  one-cycle pulse when a burst completes

module blink_timer #(
  parameter int HALF_PERIOD = 25000000,
  parameter int CNT_W       = 25,
  parameter int DIGITS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blink_en,
  input  logic              start,
  input  logic [3:0]        burst_len,
  input  logic [DIGITS-1:0] blink_mask,
`ifdef BLINK_PAUSE_EN
  input  logic              pause,
`endif
  output logic [DIGITS-1:0] isOn,
  output logic              phase,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONT  = 2'd1,
    BURST = 2'd2
  } state_t;

  // Terminal count of the half-period counter.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [3:0]       remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // run gates the blink timing only; mode changes are never paused.
  logic run;
`ifdef BLINK_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  logic at_term;
  assign at_term = (cnt_q == TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= 1'b1;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE, CONT: begin
        if (start) begin
          // start outranks blink_en, and a zero-length burst completes at once.
          if (burst_len != 4'd0) begin
            state_d     = BURST;
            cnt_d       = '0;
            phase_d     = 1'b0;
            remaining_d = burst_len;
            busy_d      = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b1;
            done_d  = 1'b1;
          end
        end else if (state_q == IDLE) begin
          cnt_d   = '0;
          phase_d = 1'b1;
          if (blink_en) begin
            state_d = CONT;
            phase_d = 1'b0;
          end
        end else if (!blink_en) begin
          // Leaving continuous mode is immediate, not at a phase boundary.
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else if (run) begin
          if (at_term) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      BURST: begin
        // start and blink_en are deliberately not looked at until completion.
        if (run) begin
          if (at_term) begin
            cnt_d = '0;
            if (phase_q) begin
              // End of an on half closes one blink.
              remaining_d = remaining_q - 4'd1;
              if (remaining_q == 4'd1) begin
                state_d = blink_en ? CONT : IDLE;
                phase_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                phase_d = 1'b0;
              end
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Combinational from the registered phase so mask edits apply immediately.
  assign isOn  = ~blink_mask | {DIGITS{phase_q}};
  assign phase = phase_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
